// File: rtl/ev_level_fsm.sv
// Up/down level tracker driven by rising edges of Increase/Decrease, with registered flags.
// Optional input debounce filter enabled by defining EV_DEBOUNCE_EN.
module ev_level_fsm #(
  parameter int unsigned LEVELS      = 8,
  parameter int unsigned RESET_LEVEL = 0,
  parameter bit          WRAP        = 1'b0,
  parameter int unsigned DB_CYCLES   = 4,
  localparam int unsigned LW         = (LEVELS > 2) ? $clog2(LEVELS) : 1
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Increase,
  input  logic          Decrease,
  output logic [LW-1:0] Level,
  output logic          AtMax,
  output logic          AtMin,
  output logic          Changed,
  output logic          Limit
);

  localparam int unsigned LWP1 = LW + 1;
  localparam logic [LW:0] MaxExt = LWP1'(LEVELS - 1);

  if (LEVELS < 2 || RESET_LEVEL >= LEVELS || DB_CYCLES < 1) begin : g_param_err
    $error("ev_level_fsm: illegal parameter combination");
  end

  logic [1:0] raw;
  logic [1:0] filt;
  assign raw = {Decrease, Increase};

`ifdef EV_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DB_CYCLES + 1);

  logic [1:0]    filt_q, filt_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  // Filtered value flips once the raw input has disagreed for DB_CYCLES samples in a row.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (raw[i] != filt_q[i]) begin
        if (cnt_q[i] == CW'(DB_CYCLES - 1)) begin
          filt_d[i] = raw[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      filt_q <= raw;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      filt_q <= filt_d;
      for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign filt = filt_q;
`else
  assign filt = raw;
`endif

  logic          inc_q, dec_q;
  logic          inc_ev, dec_ev;
  logic [LW-1:0] level_q, level_d;
  logic [LW:0]   level_ext;
  logic          at_max_q, at_max_d;
  logic          at_min_q, at_min_d;
  logic          changed_q, changed_d;
  logic          limit_q, limit_d;

  assign inc_ev    = filt[0] & ~inc_q;
  assign dec_ev    = filt[1] & ~dec_q;
  assign level_ext = {1'b0, level_q};

  always_comb begin
    level_d = level_q;
    limit_d = 1'b0;
    if (inc_ev && !dec_ev) begin
      if (level_ext == MaxExt) begin
        limit_d = 1'b1;
        if (WRAP) level_d = '0;
      end else begin
        level_d = LW'(level_ext + 1'b1);
      end
    end else if (dec_ev && !inc_ev) begin
      if (level_ext == '0) begin
        limit_d = 1'b1;
        if (WRAP) level_d = LW'(MaxExt);
      end else begin
        level_d = LW'(level_ext - 1'b1);
      end
    end
    changed_d = (level_d != level_q);
    // Flags decode the next state so they line up with the registered Level.
    at_max_d  = ({1'b0, level_d} == MaxExt);
    at_min_d  = (level_d == '0);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      // Edge registers track the inputs so a level held through reset is not an event.
      inc_q     <= raw[0];
      dec_q     <= raw[1];
      level_q   <= LW'(RESET_LEVEL);
      at_max_q  <= (RESET_LEVEL == LEVELS - 1);
      at_min_q  <= (RESET_LEVEL == 0);
      changed_q <= 1'b0;
      limit_q   <= 1'b0;
    end else begin
      inc_q     <= filt[0];
      dec_q     <= filt[1];
      level_q   <= level_d;
      at_max_q  <= at_max_d;
      at_min_q  <= at_min_d;
      changed_q <= changed_d;
      limit_q   <= limit_d;
    end
  end

  assign Level   = level_q;
  assign AtMax   = at_max_q;
  assign AtMin   = at_min_q;
  assign Changed = changed_q;
  assign Limit   = limit_q;

endmodule
